// File: rtl/counter_arbiter_if.sv
// Bus between timer clients and the shared interval counter: requests and
// durations in; grant, completion pulse and live count out.
interface counter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic                   clr;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] dur;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       cnt;

  modport master (output clr, req, dur, input gnt, done, busy, cnt);
  modport slave  (input clr, req, dur, output gnt, done, busy, cnt);
endinterface

// File: rtl/counter_arbiter.sv
// Shares one WIDTH-bit interval counter among N_REQ requesters, one at a time.
// Define COUNTER_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  counter_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt, gnt_nxt, done, done_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, dur_q, dur_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, win;
  logic [WIDTH-1:0] dur_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_dur
    assign dur_arr[i] = bus.dur[i*WIDTH +: WIDTH];
  end

`ifdef COUNTER_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (bus.req[IDX_W'(k)]) win = IDX_W'(k);
  end
`else
  logic [IDX_W-1:0] rr_ptr, rr_nxt, idx_inc;

  assign idx_inc = (int'(idx) == N_REQ-1) ? '0 : idx + IDX_W'(1);
  // Pointer advances past the owner whenever RUN is left (done or cancel).
  assign rr_nxt  = (state == RUN && state_nxt == IDLE) ? idx_inc : rr_ptr;

  // Scan from the farthest offset down so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    win = '0;
    j   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req[j]) win = j;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    cnt_nxt   = cnt;
    dur_nxt   = dur_q;
    idx_nxt   = idx;
    case (state)
      IDLE: if (|bus.req && !bus.clr) begin
        state_nxt = RUN;
        gnt_nxt   = N_REQ'(1) << win;
        dur_nxt   = dur_arr[win];
        cnt_nxt   = '0;
        idx_nxt   = win;
      end
      RUN: begin
        if (bus.clr || !bus.req[idx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt == dur_q) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          done_nxt  = gnt;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      cnt   <= '0;
      dur_q <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      cnt   <= cnt_nxt;
      dur_q <= dur_nxt;
      idx   <= idx_nxt;
    end
  end

  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.busy = (state == RUN);
  assign bus.cnt  = cnt;
endmodule
